// File: rtl/uc_arbiter_pq.sv
// Unit-clause arbiter: buffers memory unit literals, then broadcasts the smallest-magnitude
// literal among queue head and engine heads, dropping duplicates and flagging conflicts.
// Optional saturating statistics counters are enabled with `define UCA_STATS_EN.
module uc_arbiter_pq #(
  parameter int NUM_ENGINE = 4,
  parameter int VAR_MAX    = 127,
  parameter int Q_DEPTH    = 16,
  localparam int LIT_W     = $clog2(VAR_MAX+1)+1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          mem2uca_valid,
  output logic                          mem2uca_ready,
  input  logic signed [LIT_W-1:0]       mem2uca,
  input  logic                          mem2uca_done,
  input  logic [NUM_ENGINE*LIT_W-1:0]   eng2uca_min,
  input  logic [NUM_ENGINE-1:0]         eng2uca_valid,
  output logic [NUM_ENGINE-1:0]         uca2eng_pop,
  output logic signed [LIT_W-1:0]       uca2eng,
  output logic                          uca2eng_valid,
  input  logic [NUM_ENGINE-1:0]         uca2eng_full,
  output logic                          conflict,
  output logic [LIT_W-2:0]              conflict_var,
  output logic                          idle
`ifdef UCA_STATS_EN
  ,
  output logic [15:0]                   stat_bcast_cnt,
  output logic [15:0]                   stat_dup_cnt
`endif
);

  localparam int MAG_W = LIT_W-1;
  localparam int QA_W  = $clog2(Q_DEPTH);
  localparam int PTR_W = QA_W+1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MERGE, S_CONFLICT} state_t;

  function automatic logic [MAG_W-1:0] mag_of(input logic signed [LIT_W-1:0] lit);
    logic signed [LIT_W-1:0] a;
    a = lit[LIT_W-1] ? -lit : lit;
    return a[MAG_W-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic signed [LIT_W-1:0] q_mem [Q_DEPTH];
  logic [PTR_W-1:0]        q_wr_ptr_q, q_wr_ptr_d, q_rd_ptr_q, q_rd_ptr_d;
  logic [VAR_MAX:0]        assigned_q, assigned_d, value_q, value_d;
  logic signed [LIT_W-1:0] bcast_q, bcast_d;
  logic                    bcast_vld_q, bcast_vld_d;
  logic                    conflict_q, conflict_d;
  logic [MAG_W-1:0]        conflict_var_q, conflict_var_d;

  logic                    q_empty, q_full, q_push, q_pop, mem_xfer, stall, take;
  logic signed [LIT_W-1:0] q_head, eng_lit, win_lit;
  logic [MAG_W-1:0]        win_mag;
  logic                    win_vld, win_q;
  logic [NUM_ENGINE-1:0]   win_oh;
  logic                    is_zero, is_assigned, win_pol, new_bcast, dup, conf;

  assign q_empty  = (q_wr_ptr_q == q_rd_ptr_q);
  assign q_full   = (q_wr_ptr_q[QA_W] != q_rd_ptr_q[QA_W]) &&
                    (q_wr_ptr_q[QA_W-1:0] == q_rd_ptr_q[QA_W-1:0]);
  assign q_head   = q_mem[q_rd_ptr_q[QA_W-1:0]];

  assign mem2uca_ready = (state_q == S_LOAD) & ~q_full;
  assign mem_xfer      = mem2uca_valid & mem2uca_ready;
  // Zero literals complete the handshake but never occupy a queue slot.
  assign q_push        = mem_xfer & (mem2uca != '0);
  assign stall         = bcast_vld_q & (|uca2eng_full);

  // Strict less-than keeps the queue, then the lowest engine, on equal magnitudes.
  always_comb begin
    win_vld = 1'b0;
    win_lit = '0;
    win_mag = '0;
    win_q   = 1'b0;
    win_oh  = '0;
    eng_lit = '0;
    if (!q_empty) begin
      win_vld = 1'b1;
      win_lit = q_head;
      win_mag = mag_of(q_head);
      win_q   = 1'b1;
    end
    for (int i = 0; i < NUM_ENGINE; i++) begin
      eng_lit = eng2uca_min[i*LIT_W +: LIT_W];
      if (eng2uca_valid[i] && (!win_vld || (mag_of(eng_lit) < win_mag))) begin
        win_vld    = 1'b1;
        win_lit    = eng_lit;
        win_mag    = mag_of(eng_lit);
        win_q      = 1'b0;
        win_oh     = '0;
        win_oh[i]  = 1'b1;
      end
    end
  end

  assign take        = (state_q == S_MERGE) & ~stall & win_vld;
  assign uca2eng_pop = take ? win_oh : '0;
  assign q_pop       = take & win_q;

  assign is_zero     = (win_lit == '0);
  assign is_assigned = assigned_q[win_mag];
  assign win_pol     = ~win_lit[LIT_W-1];
  assign new_bcast   = take & ~is_zero & ~is_assigned;
  assign dup         = take & ~is_zero & is_assigned & (value_q[win_mag] == win_pol);
  assign conf        = take & ~is_zero & is_assigned & (value_q[win_mag] != win_pol);

  always_comb begin
    state_d        = state_q;
    q_wr_ptr_d     = q_wr_ptr_q + {{(PTR_W-1){1'b0}}, q_push};
    q_rd_ptr_d     = q_rd_ptr_q + {{(PTR_W-1){1'b0}}, q_pop};
    assigned_d     = assigned_q;
    value_d        = value_q;
    bcast_d        = bcast_q;
    bcast_vld_d    = 1'b0;
    conflict_d     = conflict_q;
    conflict_var_d = conflict_var_q;
    case (state_q)
      S_IDLE:  state_d = S_LOAD;
      S_LOAD:  if (mem2uca_done && !mem_xfer) state_d = S_MERGE;
      S_MERGE: if (conf) state_d = S_CONFLICT;
      default: state_d = state_q;
    endcase
    if (stall) begin
      bcast_vld_d = bcast_vld_q;
    end else if (new_bcast) begin
      bcast_d              = win_lit;
      bcast_vld_d          = 1'b1;
      assigned_d[win_mag]  = 1'b1;
      value_d[win_mag]     = win_pol;
    end
    if (conf) begin
      conflict_d     = 1'b1;
      conflict_var_d = win_mag;
    end
    if (clear) begin
      state_d        = S_IDLE;
      q_wr_ptr_d     = '0;
      q_rd_ptr_d     = '0;
      assigned_d     = '0;
      value_d        = '0;
      bcast_d        = '0;
      bcast_vld_d    = 1'b0;
      conflict_d     = 1'b0;
      conflict_var_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      q_wr_ptr_q     <= '0;
      q_rd_ptr_q     <= '0;
      assigned_q     <= '0;
      value_q        <= '0;
      bcast_q        <= '0;
      bcast_vld_q    <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
    end else begin
      state_q        <= state_d;
      q_wr_ptr_q     <= q_wr_ptr_d;
      q_rd_ptr_q     <= q_rd_ptr_d;
      assigned_q     <= assigned_d;
      value_q        <= value_d;
      bcast_q        <= bcast_d;
      bcast_vld_q    <= bcast_vld_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) q_mem[q_wr_ptr_q[QA_W-1:0]] <= mem2uca;
  end

  assign uca2eng       = bcast_q;
  assign uca2eng_valid = bcast_vld_q;
  assign conflict      = conflict_q;
  assign conflict_var  = conflict_var_q;
  assign idle          = (state_q == S_MERGE) & q_empty & ~(|eng2uca_valid) & ~bcast_vld_q;

`ifdef UCA_STATS_EN
  logic [15:0] bcast_cnt_q, bcast_cnt_d, dup_cnt_q, dup_cnt_d;

  always_comb begin
    bcast_cnt_d = bcast_cnt_q;
    dup_cnt_d   = dup_cnt_q;
    if (new_bcast && !stall && bcast_cnt_q != 16'hFFFF) bcast_cnt_d = bcast_cnt_q + 16'd1;
    if (dup && dup_cnt_q != 16'hFFFF) dup_cnt_d = dup_cnt_q + 16'd1;
    if (clear) begin
      bcast_cnt_d = '0;
      dup_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcast_cnt_q <= '0;
      dup_cnt_q   <= '0;
    end else begin
      bcast_cnt_q <= bcast_cnt_d;
      dup_cnt_q   <= dup_cnt_d;
    end
  end

  assign stat_bcast_cnt = bcast_cnt_q;
  assign stat_dup_cnt   = dup_cnt_q;
`endif

endmodule

// File: tb/tb_uc_arbiter_pq.sv
// Directed bench for uc_arbiter_pq: vector table for engine-only selection plus
// hand-written multi-cycle sequences for loading, conflicts, stalls and restarts.
module tb_uc_arbiter_pq;

  logic              clk = 1'b0;
  logic              rst, clear, mem2uca_valid, mem2uca_done;
  logic              mem2uca_ready;
  logic signed [7:0] mem2uca;
  logic [31:0]       eng2uca_min;
  logic [3:0]        eng2uca_valid, uca2eng_full, uca2eng_pop;
  logic signed [7:0] uca2eng;
  logic              uca2eng_valid, conflict, idle;
  logic [6:0]        conflict_var;
`ifdef UCA_STATS_EN
  logic [15:0]       stat_bcast_cnt, stat_dup_cnt;
`endif

  uc_arbiter_pq #(.NUM_ENGINE(4), .VAR_MAX(127), .Q_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .mem2uca_valid(mem2uca_valid), .mem2uca_ready(mem2uca_ready), .mem2uca(mem2uca),
    .mem2uca_done(mem2uca_done), .eng2uca_min(eng2uca_min), .eng2uca_valid(eng2uca_valid),
    .uca2eng_pop(uca2eng_pop), .uca2eng(uca2eng), .uca2eng_valid(uca2eng_valid),
    .uca2eng_full(uca2eng_full), .conflict(conflict), .conflict_var(conflict_var),
    .idle(idle)
`ifdef UCA_STATS_EN
    , .stat_bcast_cnt(stat_bcast_cnt), .stat_dup_cnt(stat_dup_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  ev;
    logic [31:0] heads;
    logic [3:0]  full;
    logic [3:0]  pop;
    logic        vld;
    int          lit;
    logic        cf;
    int          cv;
  } vec_t;
  vec_t vt[$];

  logic signed [7:0] feed [4][4];
  int                fcnt [4];
  int                fidx [4];
  logic signed [7:0] ld [20];
  logic signed [7:0] bc[$];
  int                bcyc[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int h3, input int h2, input int h1, input int h0);
    return {h3[7:0], h2[7:0], h1[7:0], h0[7:0]};
  endfunction

  task automatic addv(input logic [3:0] ev, input logic [31:0] heads, input logic [3:0] full,
                      input logic [3:0] pop, input logic vld, input int lit,
                      input logic cf, input int cv);
    vec_t v;
    v.ev = ev; v.heads = heads; v.full = full; v.pop = pop;
    v.vld = vld; v.lit = lit; v.cf = cf; v.cv = cv;
    vt.push_back(v);
  endtask

  task automatic drive_eng();
    for (int i = 0; i < 4; i++) begin
      if (fidx[i] < fcnt[i]) begin
        eng2uca_valid[i]       = 1'b1;
        eng2uca_min[i*8 +: 8]  = feed[i][fidx[i]];
      end else begin
        eng2uca_valid[i]       = 1'b0;
        eng2uca_min[i*8 +: 8]  = 8'd0;
      end
    end
  endtask

  // One clock: present engine heads, sample pops before the edge, outputs after it.
  task automatic step(output logic [3:0] p);
    drive_eng();
    #1 p = uca2eng_pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (p[i]) fidx[i]++;
    if (uca2eng_valid) begin
      bc.push_back(uca2eng);
      bcyc.push_back(cyc);
    end
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1; mem2uca_valid = 1'b0; mem2uca_done = 1'b0;
    eng2uca_valid = '0; eng2uca_min = '0; uca2eng_full = '0;
    for (int i = 0; i < 4; i++) begin fcnt[i] = 0; fidx[i] = 0; end
    bc.delete(); bcyc.delete();
    @(posedge clk);
    #1 clear = 1'b0;
    chk({tag, "_clr_conflict"}, conflict, 0);
    chk({tag, "_clr_cvar"}, conflict_var, 0);
    chk({tag, "_clr_valid"}, uca2eng_valid, 0);
    chk({tag, "_clr_lit"}, uca2eng, 0);
    chk({tag, "_clr_ready"}, mem2uca_ready, 0);
    chk({tag, "_clr_idle"}, idle, 0);
  endtask

  task automatic load(input string tag, input int n);
    int w, idx, g;
    logic rdy;
    w = 0;
    while (!mem2uca_ready && w < 8) begin @(posedge clk); #1; w++; end
    chk({tag, "_load_ready"}, mem2uca_ready, 1);
    idx = 0; g = 0;
    while (idx < n && g < 64) begin
      mem2uca_valid = 1'b1;
      mem2uca = ld[idx];
      rdy = mem2uca_ready;
      @(posedge clk);
      #1;
      if (rdy) idx++;
      g++;
    end
    mem2uca_valid = 1'b0;
    mem2uca_done  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] p;
    int k, acc, g;
    logic rdy;
    rst = 1'b0; clear = 1'b0; mem2uca_valid = 1'b0; mem2uca_done = 1'b0; mem2uca = '0;
    eng2uca_min = '0; eng2uca_valid = '0; uca2eng_full = '0;
    for (int i = 0; i < 4; i++) begin fcnt[i] = 0; fidx[i] = 0; end

    // Reset values, then IDLE -> LOAD on the first edge after release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", mem2uca_ready, 0);
    chk("rst_valid", uca2eng_valid, 0);
    chk("rst_lit", uca2eng, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_cvar", conflict_var, 0);
    chk("rst_pop", uca2eng_pop, 0);
    chk("rst_idle", idle, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_load_ready", mem2uca_ready, 1);

    // Memory-only stream 10..50
    for (int i = 0; i < 5; i++) ld[i] = 8'(10 * (i + 1));
    load("b", 5);
    for (int i = 0; i < 6; i++) step(p);
    chk("b_count", bc.size(), 5);
    for (int i = 0; i < bc.size() && i < 5; i++) chk($sformatf("b_lit%0d", i), bc[i], 10 * (i + 1));
    if (bc.size() == 5) chk("b_consecutive", bcyc[4] - bcyc[0], 4);
    chk("b_idle", idle, 1);

    // Engine-only selection table from an empty queue and a fresh table
    do_clear("v");
    load("v", 0);
    addv(4'b0000, pk(0, 0, 0, 0),   4'b0000, 4'b0000, 0, 0,  0, 0);
    addv(4'b0011, pk(0, 0, -2, 5),  4'b0000, 4'b0010, 1, -2, 0, 0);
    addv(4'b0001, pk(0, 0, 0, 5),   4'b0000, 4'b0001, 1, 5,  0, 0);
    addv(4'b0110, pk(0, -9, 9, 0),  4'b0000, 4'b0010, 1, 9,  0, 0);
    addv(4'b0100, pk(0, 9, 0, 0),   4'b0000, 4'b0100, 0, 0,  0, 0);
    addv(4'b1000, pk(7, 0, 0, 0),   4'b0000, 4'b1000, 1, 7,  0, 0);
    addv(4'b1000, pk(8, 0, 0, 0),   4'b0100, 4'b0000, 1, 7,  0, 0);
    addv(4'b1000, pk(8, 0, 0, 0),   4'b0000, 4'b1000, 1, 8,  0, 0);
    addv(4'b0001, pk(0, 0, 0, 1),   4'b1111, 4'b0000, 1, 8,  0, 0);
    addv(4'b0001, pk(0, 0, 0, 1),   4'b0000, 4'b0001, 1, 1,  0, 0);
    addv(4'b0000, pk(0, 0, 0, 0),   4'b1111, 4'b0000, 1, 1,  0, 0);
    addv(4'b0000, pk(0, 0, 0, 0),   4'b0000, 4'b0000, 0, 0,  0, 0);
    addv(4'b0001, pk(0, 0, 0, 3),   4'b1111, 4'b0001, 1, 3,  0, 0);
    addv(4'b0001, pk(0, 0, 0, -5),  4'b0000, 4'b0001, 0, 0,  1, 5);
    addv(4'b0001, pk(0, 0, 0, 6),   4'b0000, 4'b0000, 0, 0,  1, 5);
    for (int r = 0; r < vt.size(); r++) begin
      eng2uca_valid = vt[r].ev;
      eng2uca_min   = vt[r].heads;
      uca2eng_full  = vt[r].full;
      #1 chk($sformatf("v%0d_pop", r), uca2eng_pop, vt[r].pop);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", r), uca2eng_valid, vt[r].vld);
      if (vt[r].vld) chk($sformatf("v%0d_lit", r), uca2eng, vt[r].lit);
      chk($sformatf("v%0d_conflict", r), conflict, vt[r].cf);
      chk($sformatf("v%0d_cvar", r), conflict_var, vt[r].cv);
    end

    // Queue {5} against engine heads {-1,3,-3,5}
    do_clear("c");
    ld[0] = 5;
    load("c", 1);
    feed[0][0] = -1; feed[1][0] = 3; feed[2][0] = -3; feed[3][0] = 5;
    for (int i = 0; i < 4; i++) fcnt[i] = 1;
    step(p); chk("c_pop1", p, 4'b0001); chk("c_lit1", uca2eng, -1); chk("c_vld1", uca2eng_valid, 1);
    step(p); chk("c_pop2", p, 4'b0010); chk("c_lit2", uca2eng, 3);  chk("c_vld2", uca2eng_valid, 1);
    step(p); chk("c_pop3", p, 4'b0100); chk("c_vld3", uca2eng_valid, 0);
    chk("c_conflict", conflict, 1);
    chk("c_cvar", conflict_var, 3);
    step(p); chk("c_pop_held", p, 4'b0000); chk("c_vld_held", uca2eng_valid, 0);
    chk("c_ready_held", mem2uca_ready, 0);

    // Clear out of CONFLICT wipes the table: -3 is now a fresh assignment
    do_clear("g");
    load("g", 0);
    feed[0][0] = -3; fcnt[0] = 1;
    step(p); chk("g_pop", p, 4'b0001); chk("g_vld", uca2eng_valid, 1);
    chk("g_lit", uca2eng, -3); chk("g_conflict", conflict, 0);

    // Same literal from queue and engine 0: queue wins, engine copy is a duplicate
    do_clear("d");
    ld[0] = 7;
    load("d", 1);
    feed[0][0] = 7; fcnt[0] = 1;
    step(p); chk("d_pop1", p, 4'b0000); chk("d_lit1", uca2eng, 7); chk("d_vld1", uca2eng_valid, 1);
    step(p); chk("d_pop2", p, 4'b0001); chk("d_vld2", uca2eng_valid, 0);
    step(p);
    chk("d_bcast_count", bc.size(), 1);
`ifdef UCA_STATS_EN
    chk("d_stat_dup", stat_dup_cnt, 1);
    chk("d_stat_bcast", stat_bcast_cnt, 1);
`endif

    // Queue full after 16 entries; 17 and 18 arrive via engine 0
    do_clear("e");
    g = 0;
    while (!mem2uca_ready && g < 8) begin @(posedge clk); #1; g++; end
    k = 1; acc = 0; g = 0;
    while (acc < 16 && g < 60) begin
      mem2uca_valid = 1'b1; mem2uca = 8'(k);
      rdy = mem2uca_ready;
      @(posedge clk);
      #1;
      if (rdy) begin acc++; k++; end
      g++;
    end
    chk("e_accepted", acc, 16);
    mem2uca = 8'sd17;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("e_full_ready%0d", i), mem2uca_ready, 0);
      @(posedge clk);
      #1;
    end
    mem2uca_valid = 1'b0; mem2uca_done = 1'b1;
    @(posedge clk);
    #1;
    feed[0][0] = 17; feed[0][1] = 18; fcnt[0] = 2;
    for (int i = 0; i < 20; i++) step(p);
    chk("e_count", bc.size(), 18);
    for (int i = 0; i < bc.size() && i < 18; i++) chk($sformatf("e_lit%0d", i), bc[i], i + 1);
    if (bc.size() == 18) chk("e_consecutive", bcyc[17] - bcyc[0], 17);

    // Stall on uca2eng_full[2] while 4 is being broadcast
    do_clear("f");
    ld[0] = 3; ld[1] = 4; ld[2] = 5;
    load("f", 3);
    feed[1][0] = 9; fcnt[1] = 1;
    step(p);
    step(p); chk("f_lit4", uca2eng, 4);
    uca2eng_full = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step(p);
      chk($sformatf("f_stall_pop%0d", i), p, 4'b0000);
      chk($sformatf("f_stall_lit%0d", i), uca2eng, 4);
      chk($sformatf("f_stall_vld%0d", i), uca2eng_valid, 1);
    end
    uca2eng_full = 4'b0000;
    bc.delete(); bcyc.delete();
    for (int i = 0; i < 3; i++) step(p);
    chk("f_resume_count", bc.size(), 2);
    if (bc.size() == 2) begin
      chk("f_resume0", bc[0], 5);
      chk("f_resume1", bc[1], 9);
    end

    // Asynchronous reset in the middle of a broadcast
    do_clear("h");
    ld[0] = 2;
    load("h", 1);
    step(p); chk("h_vld_before", uca2eng_valid, 1);
    rst = 1'b0;
    #1;
    chk("h_rst_vld", uca2eng_valid, 0);
    chk("h_rst_lit", uca2eng, 0);
    chk("h_rst_ready", mem2uca_ready, 0);
    chk("h_rst_idle", idle, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
